alu_pipe: RTL and testbench

- Parametrised, registered successor to the single-cycle combinational ALU in the 16-bit datapath.
- Adds valid/ready handshakes on both sides and a registered result with flags.
- Adds correct saturation for both ADD and SUB.
- Adds a multi-cycle signed saturating multiply (MUL) executed by an iterative shift-add FSM.
- Sits between the decode/register-read stage and writeback. Can stall the pipe via in_ready.

---
 rtl/alu_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready handshakes, saturating ADD/SUB and an
// iterative shift-add signed multiply that stalls the input side while it runs.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter bit SAT   = 1'b1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    input  logic [3:0]       alu_op,
    input  logic [SHW-1:0]   sh_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dst,
    output logic             ov,
    output logic             zr,
    output logic             ng,
    output logic [1:0]       dbg_state
);

    localparam int MSB  = WIDTH - 1;
    localparam int HALF = WIDTH / 2;
    localparam int CNTW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_LHB = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [WIDTH-1:0] MAXV     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     ma_q, ma_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic                 msign_q, msign_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     dst_q, dst_d;
    logic                 ov_q, ov_d;
    logic                 zr_q, zr_d;
    logic                 ng_q, ng_d;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; ready never depends on valid from the same side.
    logic accept;
    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath
    logic [WIDTH-1:0] sum, dif, sat_val, alu_res;
    logic             add_ov, sub_ov, alu_ov;

    assign sum     = src0 + src1;
    assign dif     = src0 - src1;
    assign add_ov  = (src0[MSB] == src1[MSB]) && (sum[MSB] != src0[MSB]);
    assign sub_ov  = (src0[MSB] != src1[MSB]) && (dif[MSB] != src0[MSB]);
    // Overflow direction always follows src0's sign for both ADD and SUB.
    assign sat_val = src0[MSB] ? MINV : MAXV;

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_ov  = add_ov;
                alu_res = (add_ov && SAT) ? sat_val : sum;
            end
            OP_SUB: begin
                alu_ov  = sub_ov;
                alu_res = (sub_ov && SAT) ? sat_val : dif;
            end
            OP_AND:  alu_res = src0 & src1;
            OP_NOR:  alu_res = ~(src0 | src1);
            OP_SLL:  alu_res = src0 << sh_amt;
            OP_SRL:  alu_res = src0 >> sh_amt;
            OP_SRA:  alu_res = $unsigned($signed(src0) >>> sh_amt);
            OP_LHB:  alu_res = {src1[HALF-1:0], src0[HALF-1:0]};
            default: begin
                alu_res = '0;
                alu_ov  = 1'b0;
            end
        endcase
    end

    // Multiply datapath: unsigned magnitudes, sign restored at the end.
    logic [WIDTH-1:0]   abs0, abs1;
    logic [2*WIDTH-1:0] partial, addend, prod;
    logic [WIDTH:0]     prod_top;
    logic               mul_ov;
    logic [WIDTH-1:0]   mul_res;

    assign abs0     = src0[MSB] ? -src0 : src0;
    assign abs1     = src1[MSB] ? -src1 : src1;
    assign partial  = {{WIDTH{1'b0}}, ma_q} << cnt_q;
    assign addend   = mb_q[cnt_q] ? partial : '0;
    assign prod     = msign_q ? -acc_q : acc_q;
    assign prod_top = prod[2*WIDTH-1:WIDTH-1];
    // In range exactly when the upper half plus the result MSB is a pure sign extension.
    assign mul_ov   = !((&prod_top) || !(|prod_top));
    assign mul_res  = (mul_ov && SAT) ? (prod[2*WIDTH-1] ? MINV : MAXV) : prod[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        msign_d = msign_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (alu_op == OP_MUL)) begin
                    ma_d    = abs0;
                    mb_d    = abs1;
                    msign_d = src0[MSB] ^ src1[MSB];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q + addend;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        dst_d       = dst_q;
        ov_d        = ov_q;
        zr_d        = zr_q;
        ng_d        = ng_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && (alu_op != OP_MUL)) begin
            out_valid_d = 1'b1;
            dst_d       = alu_res;
            ov_d        = alu_ov;
            zr_d        = (alu_res == '0);
            ng_d        = alu_res[MSB];
        end else if (state_q == S_FIN) begin
            out_valid_d = 1'b1;
            dst_d       = mul_res;
            ov_d        = mul_ov;
            zr_d        = (mul_res == '0);
            ng_d        = mul_res[MSB];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            msign_q     <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            dst_q       <= '0;
            ov_q        <= 1'b0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            msign_q     <= msign_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            dst_q       <= dst_d;
            ov_q        <= ov_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dst       = dst_q;
    assign ov        = ov_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a saturating and a wrapping instance share stimulus and
// are checked every cycle against an arithmetic model plus directed literals.
module tb_alu_pipe;

    localparam int W   = 16;
    localparam int SHW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [W-1:0]   src0, src1;
    logic [3:0]     alu_op;
    logic [SHW-1:0] sh_amt;
    logic           out_ready;

    logic           in_ready, out_valid, ov, zr, ng;
    logic [W-1:0]   dst;
    logic [1:0]     dbg_state;
    logic           in_ready_w, out_valid_w, ov_w, zr_w, ng_w;
    logic [W-1:0]   dst_w;
    logic [1:0]     dbg_state_w;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .SAT(1'b1), .SHW(SHW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src0(src0), .src1(src1), .alu_op(alu_op), .sh_amt(sh_amt),
        .out_valid(out_valid), .out_ready(out_ready), .dst(dst),
        .ov(ov), .zr(zr), .ng(ng), .dbg_state(dbg_state)
    );

    alu_pipe #(.WIDTH(W), .SAT(1'b0), .SHW(SHW)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .src0(src0), .src1(src1), .alu_op(alu_op), .sh_amt(sh_amt),
        .out_valid(out_valid_w), .out_ready(out_ready), .dst(dst_w),
        .ov(ov_w), .zr(zr_w), .ng(ng_w), .dbg_state(dbg_state_w)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_drained = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {ov, zr, ng, dst} from plain signed arithmetic.
    function automatic logic [W+2:0] model_op(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [SHW-1:0] sh,
                                              input bit sat);
        longint sa, sb, r, maxv, minv;
        logic [W-1:0] res;
        logic o;
        sa   = $signed(a);
        sb   = $signed(b);
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        res  = '0;
        o    = 1'b0;
        case (op)
            4'd0, 4'd1, 4'd8: begin
                r = (op == 4'd0) ? sa + sb : (op == 4'd1) ? sa - sb : sa * sb;
                o = (r > maxv) || (r < minv);
                if (o && sat) res = (r > 0) ? maxv[W-1:0] : minv[W-1:0];
                else          res = r[W-1:0];
            end
            4'd2: res = a & b;
            4'd3: res = ~(a | b);
            4'd4: res = a << sh;
            4'd5: res = a >> sh;
            4'd6: begin
                r   = sa >>> sh;
                res = r[W-1:0];
            end
            4'd7: res = {b[W/2-1:0], a[W/2-1:0]};
            default: res = '0;
        endcase
        return {o, (res == '0), res[W-1], res};
    endfunction

    // Scoreboard: results predicted at accept time, released when the model says
    // the output register holds them.
    logic [W+2:0] exp_q[$];
    logic [W+2:0] exp0_q[$];
    bit           m_valid = 1'b0;
    int           m_busy  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp0_q.delete();
            m_valid = 1'b0;
            m_busy  = 0;
        end else begin
            logic exp_ir;
            exp_ir = (m_busy == 0) && (!m_valid || out_ready);
            check("in_ready", in_ready, exp_ir);
            check("in_ready_w", in_ready_w, exp_ir);
            check("out_valid", out_valid, m_valid);
            check("out_valid_w", out_valid_w, m_valid);
            if (m_valid && exp_q.size() > 0) begin
                check("result", {ov, zr, ng, dst}, exp_q[0]);
                check("result_w", {ov_w, zr_w, ng_w, dst_w}, exp0_q[0]);
            end
            if (out_valid && out_ready) n_drained++;
            if (m_valid && out_ready) begin
                void'(exp_q.pop_front());
                void'(exp0_q.pop_front());
                m_valid = 1'b0;
            end
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_valid = 1'b1;
            end
            if (in_valid && exp_ir) begin
                exp_q.push_back(model_op(alu_op, src0, src1, sh_amt, 1'b1));
                exp0_q.push_back(model_op(alu_op, src0, src1, sh_amt, 1'b0));
                if (alu_op == 4'd8) m_busy = W + 1;
                else                m_valid = 1'b1;
            end
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SHW-1:0] sh);
        int t;
        t        = 0;
        in_valid = 1'b1;
        alu_op   = op;
        src0     = a;
        src1     = b;
        sh_amt   = sh;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready stayed %b after %0d cycles, required 1", in_ready, t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src0     = W'($urandom);
        src1     = W'($urandom);
    endtask

    // Waits for the result of the op just accepted and pins it to literals.
    task automatic expect_res(input string name, input logic [W+2:0] e, input logic [W+2:0] e_w,
                              input int e_lat, input int e_irl);
        int lat, irl;
        lat = 0;
        irl = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (!in_ready) irl++;
            @(negedge clk);
            lat++;
        end
        if (!in_ready) irl++;
        check({name, "_lat"}, lat, e_lat);
        check({name, "_irl"}, irl, e_irl);
        check({name, "_val"}, {ov, zr, ng, dst}, e);
        check({name, "_val_w"}, {ov_w, zr_w, ng_w, dst_w}, e_w);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    int base;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        src0      = '0;
        src1      = '0;
        alu_op    = '0;
        sh_amt    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {out_valid, ov, zr, ng, dst}, '0);
        check("rst_state", {dbg_state, dbg_state_w}, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Saturating / wrapping add and subtract
        send(4'd0, 16'h7FFF, 16'h0001, 4'd0);
        expect_res("add_pos_ov", {3'b100, 16'h7FFF}, {3'b101, 16'h8000}, 0, 0);
        send(4'd0, 16'h8000, 16'hFFFF, 4'd0);
        expect_res("add_neg_ov", {3'b101, 16'h8000}, {3'b100, 16'h7FFF}, 0, 0);
        send(4'd1, 16'h8000, 16'h0001, 4'd0);
        expect_res("sub_neg_ov", {3'b101, 16'h8000}, {3'b100, 16'h7FFF}, 0, 0);
        send(4'd1, 16'h0005, 16'h0005, 4'd0);
        expect_res("sub_zero", {3'b010, 16'h0000}, {3'b010, 16'h0000}, 0, 0);

        // Logic, shifts, LHB, reserved
        send(4'd2, 16'hF0F0, 16'h3C3C, 4'd0);
        expect_res("and", {3'b000, 16'h3030}, {3'b000, 16'h3030}, 0, 0);
        send(4'd3, 16'h0F0F, 16'hF000, 4'd0);
        expect_res("nor", {3'b000, 16'h00F0}, {3'b000, 16'h00F0}, 0, 0);
        send(4'd6, 16'h8000, 16'h0000, 4'd15);
        expect_res("sra15", {3'b001, 16'hFFFF}, {3'b001, 16'hFFFF}, 0, 0);
        send(4'd5, 16'h8000, 16'h0000, 4'd15);
        expect_res("srl15", {3'b000, 16'h0001}, {3'b000, 16'h0001}, 0, 0);
        send(4'd4, 16'h0001, 16'h0000, 4'd15);
        expect_res("sll15", {3'b001, 16'h8000}, {3'b001, 16'h8000}, 0, 0);
        send(4'd4, 16'hA5A5, 16'h0000, 4'd0);
        expect_res("sll0", {3'b001, 16'hA5A5}, {3'b001, 16'hA5A5}, 0, 0);
        send(4'd7, 16'h12AB, 16'h34CD, 4'd0);
        expect_res("lhb", {3'b001, 16'hCDAB}, {3'b001, 16'hCDAB}, 0, 0);
        send(4'd12, 16'h1234, 16'h5678, 4'd3);
        expect_res("reserved", {3'b010, 16'h0000}, {3'b010, 16'h0000}, 0, 0);

        // Multiply: latency, stall length, sign handling, saturation
        send(4'd8, 16'h0003, 16'hFFFE, 4'd0);
        expect_res("mul_3xm2", {3'b001, 16'hFFFA}, {3'b001, 16'hFFFA}, W + 1, W + 1);
        send(4'd8, 16'h0100, 16'h0100, 4'd0);
        expect_res("mul_big", {3'b100, 16'h7FFF}, {3'b110, 16'h0000}, W + 1, W + 1);
        send(4'd8, 16'h8000, 16'hFFFF, 4'd0);
        expect_res("mul_min_m1", {3'b100, 16'h7FFF}, {3'b101, 16'h8000}, W + 1, W + 1);
        send(4'd8, 16'h8000, 16'h8000, 4'd0);
        expect_res("mul_min_min", {3'b100, 16'h7FFF}, {3'b110, 16'h0000}, W + 1, W + 1);
        send(4'd8, 16'hFFFF, 16'h7FFF, 4'd0);
        expect_res("mul_m1_max", {3'b001, 16'h8001}, {3'b001, 16'h8001}, W + 1, W + 1);

        // Backpressure: result held, next op queued, then drain + accept on one edge
        out_ready = 1'b0;
        send(4'd0, 16'h1111, 16'h2222, 4'd0);
        in_valid = 1'b1;
        alu_op   = 4'd1;
        src0     = 16'h0010;
        src1     = 16'h0001;
        sh_amt   = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_hold", {out_valid, ov, zr, ng, dst}, {4'b1000, 16'h3333});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next", {out_valid, ov, zr, ng, dst}, {4'b1000, 16'h000F});
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply
        send(4'd0, 16'h0001, 16'h0001, 4'd0);
        expect_res("add_small", {3'b000, 16'h0002}, {3'b000, 16'h0002}, 0, 0);
        send(4'd8, 16'h7FFF, 16'h7FFF, 4'd0);
        repeat (8) @(posedge clk);
        #2;
        check("mid_mul_state", dbg_state, 2'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_out", {out_valid, ov, zr, ng, dst}, '0);
        check("rst_async_state", dbg_state, 2'd0);
        check("rst_async_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst", {in_ready, out_valid}, 2'b10);
        repeat (25) @(negedge clk);
        @(posedge clk);
        #1;

        // Streaming single-cycle ops, one per cycle
        base = n_drained;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            alu_op   = 4'($urandom_range(0, 7));
            src0     = pick();
            src1     = pick();
            sh_amt   = SHW'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stream_count", n_drained - base, 8);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
